exec_flags_unit: RTL and testbench

//  Execute-stage datapath of the ARM-subset CPU: a 32-bit ALU implementing the 16 ARM data-processing opcodes,
//  the CPSR flag register (NZCV) with per-flag write mask, and a pipeline register on the ALU result.
//  It sits between the shifter (operand 2) and the mem/writeback stages; CPSR C feeds back to shifter and ALU.

---
 rtl/cpu_defs_pkg.sv | 36 +++
 rtl/dff_ar.sv | 22 ++
 rtl/exec_flags_unit.sv | 90 +++++++++
 tb/tb_exec_flags_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the ARM-subset CPU datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: datapath/flag widths, CPSR flag-field position, flag bit indices
// and the 16 ARM data-processing opcode encodings.
package cpu_defs;

    localparam int FULLW       = 32;
    localparam int FLAGSW      = 4;
    localparam int ALUAW       = 4;
    localparam int FLAGS_START = 28;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int N_I = 3;
    localparam int Z_I = 2;
    localparam int C_I = 1;
    localparam int V_I = 0;

    localparam logic [ALUAW-1:0] OP_AND = 4'h0;
    localparam logic [ALUAW-1:0] OP_EOR = 4'h1;
    localparam logic [ALUAW-1:0] OP_SUB = 4'h2;
    localparam logic [ALUAW-1:0] OP_RSB = 4'h3;
    localparam logic [ALUAW-1:0] OP_ADD = 4'h4;
    localparam logic [ALUAW-1:0] OP_ADC = 4'h5;
    localparam logic [ALUAW-1:0] OP_SBC = 4'h6;
    localparam logic [ALUAW-1:0] OP_RSC = 4'h7;
    localparam logic [ALUAW-1:0] OP_TST = 4'h8;
    localparam logic [ALUAW-1:0] OP_TEQ = 4'h9;
    localparam logic [ALUAW-1:0] OP_CMP = 4'hA;
    localparam logic [ALUAW-1:0] OP_CMN = 4'hB;
    localparam logic [ALUAW-1:0] OP_ORR = 4'hC;
    localparam logic [ALUAW-1:0] OP_MOV = 4'hD;
    localparam logic [ALUAW-1:0] OP_BIC = 4'hE;
    localparam logic [ALUAW-1:0] OP_MVN = 4'hF;

endpackage

// File: rtl/dff_ar.sv
// Generic register with asynchronous active-high clear to zero.
// Latency: 1 cycle from d to q.
// Backpressure: none; loads d on every rising edge outside reset.
// Ports: clk, reset (async, active-high), d (WIDTH), q (WIDTH).
module dff_ar #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/exec_flags_unit.sv
// Execute stage: 32-bit ARM data-processing ALU, NZCV flag register, registered result.
// Latency: alu_result/flags_next combinational; alu_out_q and cpsr update 1 cycle later.
// Backpressure: none; result register loads every cycle, flags load per flag_we bit.
// Ports: clk, reset (async active-high), alu_op, rn, shifter, shifter_carry, flag_we in;
//        alu_result, flags_next, alu_out_q, cpsr out (cpsr[31:28] = N,Z,C,V, rest zero).
module exec_flags_unit
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ALUAW-1:0]  alu_op,
    input  logic [FULLW-1:0]  rn,
    input  logic [FULLW-1:0]  shifter,
    input  logic              shifter_carry,
    input  logic [FLAGSW-1:0] flag_we,
    output logic [FULLW-1:0]  alu_result,
    output logic [FLAGSW-1:0] flags_next,
    output logic [FULLW-1:0]  alu_out_q,
    output logic [FULLW-1:0]  cpsr
);

    logic [FLAGSW-1:0] flags_q;
    logic [FLAGSW-1:0] flags_d;
    logic [FULLW-1:0]  op_a;
    logic [FULLW-1:0]  op_b;
    logic              cin;
    logic              arith;
    logic [FULLW-1:0]  logic_res;
    logic [FULLW:0]    sum;

    // Every arithmetic op is a single 33-bit add: subtraction feeds the
    // inverted subtrahend, so bit 32 is directly the ARM "NOT borrow" carry.
    // Carry-in for ADC/SBC/RSC is the registered C, never flags_next.
    always_comb begin
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        arith     = 1'b0;
        logic_res = '0;
        case (alu_op)
            OP_AND, OP_TST: logic_res = rn & shifter;
            OP_EOR, OP_TEQ: logic_res = rn ^ shifter;
            OP_ORR:         logic_res = rn | shifter;
            OP_MOV:         logic_res = shifter;
            OP_BIC:         logic_res = rn & ~shifter;
            OP_MVN:         logic_res = ~shifter;
            OP_SUB, OP_CMP: begin arith = 1'b1; op_a = rn;      op_b = ~shifter; cin = 1'b1;         end
            OP_RSB:         begin arith = 1'b1; op_a = shifter; op_b = ~rn;      cin = 1'b1;         end
            OP_ADD, OP_CMN: begin arith = 1'b1; op_a = rn;      op_b = shifter;  cin = 1'b0;         end
            OP_ADC:         begin arith = 1'b1; op_a = rn;      op_b = shifter;  cin = flags_q[C_I]; end
            OP_SBC:         begin arith = 1'b1; op_a = rn;      op_b = ~shifter; cin = flags_q[C_I]; end
            OP_RSC:         begin arith = 1'b1; op_a = shifter; op_b = ~rn;      cin = flags_q[C_I]; end
            default:        logic_res = '0;
        endcase
        sum = {1'b0, op_a} + {1'b0, op_b} + {{FULLW{1'b0}}, cin};
    end

    assign alu_result = arith ? sum[FULLW-1:0] : logic_res;

    // Logical ops take C from the shifter and leave V as it was.
    always_comb begin
        flags_next       = '0;
        flags_next[N_I]  = alu_result[FULLW-1];
        flags_next[Z_I]  = (alu_result == '0);
        flags_next[C_I]  = arith ? sum[FULLW] : shifter_carry;
        flags_next[V_I]  = arith ? ((op_a[FULLW-1] == op_b[FULLW-1]) &&
                                    (alu_result[FULLW-1] != op_a[FULLW-1]))
                                 : flags_q[V_I];
    end

    // Per-flag write mask: unmasked flags recirculate their current value.
    assign flags_d = (flag_we & flags_next) | (~flag_we & flags_q);

    dff_ar #(.WIDTH(FLAGSW)) u_flags_reg (
        .clk   (clk),
        .reset (reset),
        .d     (flags_d),
        .q     (flags_q)
    );

    dff_ar #(.WIDTH(FULLW)) u_result_reg (
        .clk   (clk),
        .reset (reset),
        .d     (alu_result),
        .q     (alu_out_q)
    );

    assign cpsr = {flags_q, {FLAGS_START{1'b0}}};

endmodule

// File: tb/tb_exec_flags_unit.sv
`timescale 1ns/1ps
module tb_exec_flags_unit;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_op;
    logic [31:0] rn;
    logic [31:0] shifter;
    logic        shifter_carry;
    logic [3:0]  flag_we;
    logic [31:0] alu_result;
    logic [3:0]  flags_next;
    logic [31:0] alu_out_q;
    logic [31:0] cpsr;

    int checks = 0;
    int errors = 0;

    // Reference state: NZCV and the registered result
    logic [3:0]  m_flags;
    logic [31:0] m_q;

    exec_flags_unit dut (
        .clk           (clk),
        .reset         (reset),
        .alu_op        (alu_op),
        .rn            (rn),
        .shifter       (shifter),
        .shifter_carry (shifter_carry),
        .flag_we       (flag_we),
        .alu_result    (alu_result),
        .flags_next    (flags_next),
        .alu_out_q     (alu_out_q),
        .cpsr          (cpsr)
    );

    always #5 clk = ~clk;

    // Reference ALU: true integer arithmetic in 64 bits; carry and overflow
    // are read off the mathematical result rather than bit tricks.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic sc, input logic [3:0] fl,
                                  output logic [31:0] res, output logic [3:0] nf);
        longint ua, ub, sa, sb, u, s, c_in, nc;
        logic   c, v, is_arith;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        c_in = fl[1] ? 64'd1 : 64'd0;
        nc = 64'd1 - c_in;
        is_arith = 1'b1;
        u = 0; s = 0; c = 1'b0; res = 32'h0;
        case (op)
            4'h4, 4'hB: begin u = ua + ub;        s = sa + sb;        c = (u > 64'hFFFF_FFFF); end
            4'h5:       begin u = ua + ub + c_in; s = sa + sb + c_in; c = (u > 64'hFFFF_FFFF); end
            4'h2, 4'hA: begin u = ua - ub;        s = sa - sb;        c = (ua >= ub);          end
            4'h6:       begin u = ua - ub - nc;   s = sa - sb - nc;   c = (ua >= ub + nc);     end
            4'h3:       begin u = ub - ua;        s = sb - sa;        c = (ub >= ua);          end
            4'h7:       begin u = ub - ua - nc;   s = sb - sa - nc;   c = (ub >= ua + nc);     end
            default: begin
                is_arith = 1'b0;
                case (op)
                    4'h0, 4'h8: res = a & b;
                    4'h1, 4'h9: res = a ^ b;
                    4'hC:       res = a | b;
                    4'hD:       res = b;
                    4'hE:       res = a & ~b;
                    default:    res = ~b;
                endcase
            end
        endcase
        if (is_arith) begin
            res = u[31:0];
            v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            c = sc;
            v = fl[0];
        end
        nf = {res[31], (res == 32'h0), c, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one operation, check combinational outputs, clock it, check state.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sc, input logic [3:0] we,
                        input logic dir, input logic [31:0] exp_res, input logic [3:0] exp_nf);
        logic [31:0] r;
        logic [3:0]  nf;
        alu_op = op; rn = a; shifter = b; shifter_carry = sc; flag_we = we;
        #2;
        model(op, a, b, sc, m_flags, r, nf);
        chk("alu_result", alu_result, r);
        chk("flags_next", {28'h0, flags_next}, {28'h0, nf});
        if (dir) begin
            chk("alu_result_directed", alu_result, exp_res);
            chk("flags_next_directed", {28'h0, flags_next}, {28'h0, exp_nf});
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) if (we[i]) m_flags[i] = nf[i];
        m_q = r;
        chk("cpsr", cpsr, {m_flags, 28'h0});
        chk("alu_out_q", alu_out_q, m_q);
    endtask

    initial begin
        reset = 1'b1; alu_op = 4'h0; rn = 32'h0; shifter = 32'h0;
        shifter_carry = 1'b0; flag_we = 4'h0;
        m_flags = 4'h0; m_q = 32'h0;
        #12;
        chk("reset_cpsr", cpsr, 32'h0);
        chk("reset_q", alu_out_q, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Build cpsr = F0000000: ZCV from 8..0+8..0, then N from MVN
        step(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'b0111, 1'b1, 32'h0, 4'b0111);
        step(OP_MVN, 32'h0, 32'h0, 1'b1, 4'b1000, 1'b1, 32'hFFFF_FFFF, 4'b1011);
        chk("cpsr_all_set", cpsr, 32'hF000_0000);

        // Async reset between edges clears immediately and holds across an edge
        #2; reset = 1'b1; #1;
        chk("async_rst_cpsr", cpsr, 32'h0);
        chk("async_rst_q", alu_out_q, 32'h0);
        @(posedge clk); #1;
        chk("held_rst_cpsr", cpsr, 32'h0);
        chk("held_rst_q", alu_out_q, 32'h0);
        reset = 1'b0; m_flags = 4'h0; m_q = 32'h0;

        // ADD overflow into sign bit
        step(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'b1111, 1'b1, 32'h8000_0000, 4'b1001);
        chk("add_ovf_cpsr", cpsr, 32'h9000_0000);
        chk("add_ovf_q", alu_out_q, 32'h8000_0000);

        // CMP equal, SUB negative, ADC wrap with C=1, SBC with C=0
        step(OP_CMP, 32'h5, 32'h5, 1'b0, 4'b1111, 1'b1, 32'h0, 4'b0110);
        chk("cmp_cpsr", cpsr, 32'h6000_0000);
        step(OP_ADC, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b1111, 1'b1, 32'h0, 4'b0110);
        step(OP_SUB, 32'h3, 32'h5, 1'b0, 4'b1111, 1'b1, 32'hFFFF_FFFE, 4'b1000);
        step(OP_SBC, 32'h5, 32'h2, 1'b0, 4'b1111, 1'b1, 32'h2, 4'b0010);

        // Write mask: none, then Z only
        step(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'b0000, 1'b1, 32'h8000_0000, 4'b1001);
        chk("we0_cpsr", cpsr, 32'h0000_0000 | {4'b0010, 28'h0});
        step(OP_AND, 32'h0, 32'h0, 1'b0, 4'b0100, 1'b1, 32'h0, 4'b0100);
        chk("weZ_cpsr", cpsr, 32'h6000_0000);

        // Logical ops keep V, take C from the shifter
        step(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'b1111, 1'b1, 32'h8000_0000, 4'b1001);
        step(OP_MVN, 32'h1234, 32'h0, 1'b1, 4'b1111, 1'b1, 32'hFFFF_FFFF, 4'b1011);
        step(OP_BIC, 32'hF0F0, 32'hFF00, 1'b0, 4'b1111, 1'b1, 32'h0000_00F0, 4'b0001);
        step(OP_RSB, 32'h1, 32'h0, 1'b0, 4'b1111, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        step(OP_RSC, 32'h0, 32'h0, 1'b0, 4'b1111, 1'b1, 32'hFFFF_FFFF, 4'b1000);

        // Random sweep over all opcodes, masks and operand corners
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h7FFF_FFFF;
                1: b = 32'h8000_0000;
                2: b = a;
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            step(4'($urandom_range(0, 15)), a, b, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'b0, 32'h0, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
